// File: rtl/data_mem_responder.sv
// -----------------------------------------------------------------------------
// core package + data_mem_responder
//
// The core package holds the memory-control bus type and its op encoding.
// data_mem_responder is the responder end of that bus. It accepts one
// load/store at a time from the execute-stage memory unit and checks it for
// alignment and range. It inserts WAIT_CYCLES wait states, then performs the
// access against an internal byte-addressed RAM.
//
// Ports
//   clk_i          rising-edge clock
//   rst_ni         asynchronous active-low reset
//   mem_bus_i      request: addr, w_data, mem_op, mem_rd (r_data/write_en unused)
//   flush_i        kill the in-flight request (a pending store is dropped)
//   stall_o        pipeline must hold mem_bus_i stable
//   resp_valid_o   one-cycle pulse: access complete
//   rdata_o        extended load data (0 for stores)
//   rd_o           load destination register (0 for stores and faults)
//   we_o           register-file write enable (load, rd != 0, no fault)
//   fault_o        one-cycle pulse: misaligned or out-of-range access
//   fault_addr_o   address of the most recent fault
// -----------------------------------------------------------------------------
package core;
  localparam logic       STORE_PRFX = 1'b1;
  localparam logic [3:0] MEM_NOP    = 4'b0011;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] w_data;
    logic [31:0] r_data;
    logic        write_en;
    logic [3:0]  mem_op;
    logic [4:0]  mem_rd;
  } mem_cntrl_bus_t;
endpackage

module data_mem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_CYCLES = 1,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_2000
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  core::mem_cntrl_bus_t mem_bus_i,
  input  logic                 flush_i,
  output logic                 stall_o,
  output logic                 resp_valid_o,
  output logic [31:0]          rdata_o,
  output logic [4:0]           rd_o,
  output logic                 we_o,
  output logic                 fault_o,
  output logic [31:0]          fault_addr_o
);

  localparam int unsigned IDX_W     = $clog2(DEPTH_WORDS);
  localparam logic [31:0] SPAN      = 32'(DEPTH_WORDS) << 2;
  localparam logic [3:0]  WAIT_LOAD = 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // ---------------------------------------------------------------------------
  // Helper functions
  // ---------------------------------------------------------------------------

  // Range check uses a wrapping 32-bit subtraction so addresses below
  // BASE_ADDR land far above SPAN and are rejected. funct3 widths other than
  // B/H/W have no defined access and are reported as faults.
  function automatic logic access_ok(input logic [31:0] addr, input logic [2:0] f3);
    logic [31:0] off;
    logic        ok;
    off = addr - BASE_ADDR;
    ok  = (off < SPAN);
    case (f3[1:0])
      2'b00:   ok = ok;
      2'b01:   ok = ok & ~addr[0];
      2'b10:   ok = ok & (addr[1:0] == 2'b00);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic [3:0] store_lanes(input logic [2:0] f3, input logic [1:0] lane);
    case (f3[1:0])
      2'b00:   return 4'b0001 << lane;
      2'b01:   return lane[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  // Replicating the write data means every enabled lane already holds the
  // right byte, so the RAM write needs no per-lane shifting.
  function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] wd);
    case (f3[1:0])
      2'b00:   return {4{wd[7:0]}};
      2'b01:   return {2{wd[15:0]}};
      default: return wd;
    endcase
  endfunction

  // Accesses are aligned by the time they reach RAM, so shifting the word
  // right by the lane offset puts the selected byte/half in the low bits.
  function automatic logic [31:0] load_extend(input logic [31:0] word,
                                              input logic [1:0]  lane,
                                              input logic [2:0]  f3);
    logic [31:0] shifted;
    shifted = word >> {lane, 3'b000};
    case (f3)
      core::F3_B:  return {{24{shifted[7]}}, shifted[7:0]};
      core::F3_BU: return {24'h0, shifted[7:0]};
      core::F3_H:  return {{16{shifted[15]}}, shifted[15:0]};
      core::F3_HU: return {16'h0, shifted[15:0]};
      default:     return shifted;
    endcase
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        fault_q, fault_d;
  logic [31:0] fault_addr_q, fault_addr_d;

  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  op_q, op_d;
  logic [4:0]  rd_q, rd_d;

  logic [31:0] ram [DEPTH_WORDS];

  logic             req_present;
  logic             complete;
  logic             is_store;
  logic             load_ok;
  logic             ram_we;
  logic [31:0]      ram_off;
  logic [IDX_W-1:0] ram_idx;
  logic [3:0]       ram_be;
  logic [31:0]      ram_wdata;
  logic [31:0]      ram_rword;
  logic             unused_bits;

  assign req_present = (mem_bus_i.mem_op != core::MEM_NOP);

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    fault_d = fault_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    op_d    = op_q;
    rd_d    = rd_q;

    case (state_q)
      ST_IDLE: begin
        if (req_present && !flush_i) begin
          addr_d  = mem_bus_i.addr;
          wdata_d = mem_bus_i.w_data;
          op_d    = mem_bus_i.mem_op;
          rd_d    = mem_bus_i.mem_rd;
          if (!access_ok(mem_bus_i.addr, mem_bus_i.mem_op[2:0])) begin
            // Faults skip the wait states: nothing is accessed.
            fault_d = 1'b1;
            state_d = ST_RESP;
          end else begin
            fault_d = 1'b0;
            if (WAIT_CYCLES > 0) begin
              state_d = ST_WAIT;
              cnt_d   = WAIT_LOAD;
            end else begin
              state_d = ST_RESP;
            end
          end
        end
      end
      ST_WAIT: begin
        if (flush_i) begin
          state_d = ST_IDLE;
        end else if (cnt_q == 4'd0) begin
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Response / RAM access
  // ---------------------------------------------------------------------------
  // The access happens on the edge leaving RESP; a flush in that same cycle
  // wins over completion and suppresses both the write and the pulse.
  assign complete     = (state_q == ST_RESP) && !flush_i;
  assign resp_valid_o = complete && !fault_q;
  assign fault_o      = complete && fault_q;
  assign is_store     = (op_q[3] == core::STORE_PRFX);
  assign load_ok      = resp_valid_o && !is_store;

  assign ram_off   = addr_q - BASE_ADDR;
  assign ram_idx   = ram_off[IDX_W+1:2];
  assign ram_be    = store_lanes(op_q[2:0], addr_q[1:0]);
  assign ram_wdata = store_data(op_q[2:0], wdata_q);
  assign ram_we    = resp_valid_o && is_store;
  assign ram_rword = ram[ram_idx];

  assign rdata_o = load_ok ? load_extend(ram_rword, addr_q[1:0], op_q[2:0]) : 32'h0;
  assign rd_o    = load_ok ? rd_q : 5'd0;
  assign we_o    = load_ok && (rd_q != 5'd0);

  // Reset gates stall_o so all outputs read 0 while rst_ni is low, even with
  // a request still presented on the bus.
  assign stall_o = rst_ni &&
                   (((state_q == ST_IDLE) && req_present && !flush_i) ||
                    (state_q == ST_WAIT));

  // The faulting address is visible in the same cycle as fault_o and is then
  // held in fault_addr_q until the next fault.
  assign fault_addr_d = fault_o ? addr_q : fault_addr_q;
  assign fault_addr_o = fault_addr_d;

  assign unused_bits = ^{mem_bus_i.r_data, mem_bus_i.write_en,
                         ram_off[31:IDX_W+2], ram_off[1:0]};

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= ST_IDLE;
      cnt_q        <= 4'd0;
      fault_q      <= 1'b0;
      fault_addr_q <= 32'h0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      fault_q      <= fault_d;
      fault_addr_q <= fault_addr_d;
    end
  end

  // Request payload is only consumed while the FSM is busy, so it needs no reset.
  always_ff @(posedge clk_i) begin
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
    op_q    <= op_d;
    rd_q    <= rd_d;
  end

  // Byte-enabled write. An asynchronous reset forces state_q to IDLE, which
  // drops ram_we, so a reset mid-access never commits a store.
  always_ff @(posedge clk_i) begin
    if (ram_we) begin
      for (int b = 0; b < 4; b++) begin
        if (ram_be[b]) begin
          ram[ram_idx][8*b +: 8] <= ram_wdata[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: two instances (WAIT_CYCLES=1 and 0) driven
// one at a time; a byte-array model predicts every output cycle by cycle.
module tb_data_mem_responder;

  localparam int          DEPTH = 64;
  localparam logic [31:0] BASE  = 32'h0000_2000;
  localparam logic [31:0] SPAN  = 32'(DEPTH * 4);

  localparam logic [3:0] OP_LB  = 4'b0000;
  localparam logic [3:0] OP_LH  = 4'b0001;
  localparam logic [3:0] OP_LW  = 4'b0010;
  localparam logic [3:0] OP_LBU = 4'b0100;
  localparam logic [3:0] OP_LHU = 4'b0101;
  localparam logic [3:0] OP_SB  = 4'b1000;
  localparam logic [3:0] OP_SH  = 4'b1001;
  localparam logic [3:0] OP_SW  = 4'b1010;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  core::mem_cntrl_bus_t bus [2];
  logic        flush [2];
  logic        stall [2];
  logic        valid [2];
  logic [31:0] rdata [2];
  logic [4:0]  rd    [2];
  logic        we    [2];
  logic        flt   [2];
  logic [31:0] faddr [2];

  data_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(1), .BASE_ADDR(BASE)) u_a (
    .clk_i(clk), .rst_ni(rst_n), .mem_bus_i(bus[0]), .flush_i(flush[0]),
    .stall_o(stall[0]), .resp_valid_o(valid[0]), .rdata_o(rdata[0]), .rd_o(rd[0]),
    .we_o(we[0]), .fault_o(flt[0]), .fault_addr_o(faddr[0]));

  data_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0), .BASE_ADDR(BASE)) u_b (
    .clk_i(clk), .rst_ni(rst_n), .mem_bus_i(bus[1]), .flush_i(flush[1]),
    .stall_o(stall[1]), .resp_valid_o(valid[1]), .rdata_o(rdata[1]), .rd_o(rd[1]),
    .we_o(we[1]), .fault_o(flt[1]), .fault_addr_o(faddr[1]));

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_on = 1'b0;

  // Model state and per-cycle expectations
  logic [7:0]  mdl [2][DEPTH*4];
  logic [31:0] model_faddr [2];
  logic        exp_stall [2];
  logic        exp_valid [2];
  logic [31:0] exp_rdata [2];
  logic [4:0]  exp_rd    [2];
  logic        exp_we    [2];
  logic        exp_fault [2];
  logic [31:0] exp_faddr [2];

  // Outputs captured at the last response cycle, for literal checks
  logic        last_valid, last_we, last_fault;
  logic [31:0] last_rdata, last_faddr;
  logic [4:0]  last_rd;
  time         last_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      for (int d = 0; d < 2; d++) begin
        chk($sformatf("dut%0d stall_o", d), 32'(stall[d]), 32'(exp_stall[d]));
        chk($sformatf("dut%0d resp_valid_o", d), 32'(valid[d]), 32'(exp_valid[d]));
        chk($sformatf("dut%0d rdata_o", d), rdata[d], exp_rdata[d]);
        chk($sformatf("dut%0d rd_o", d), 32'(rd[d]), 32'(exp_rd[d]));
        chk($sformatf("dut%0d we_o", d), 32'(we[d]), 32'(exp_we[d]));
        chk($sformatf("dut%0d fault_o", d), 32'(flt[d]), 32'(exp_fault[d]));
        chk($sformatf("dut%0d fault_addr_o", d), faddr[d], exp_faddr[d]);
      end
    end
  end

  function automatic bit model_fault(input logic [3:0] op, input logic [31:0] addr);
    logic [31:0] off;
    off = addr - BASE;
    if (off >= SPAN) return 1'b1;
    if (op[1:0] == 2'b01) return addr[0];
    if (op[1:0] == 2'b10) return (addr[1:0] != 2'b00);
    if (op[1:0] == 2'b11) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] model_load(input int d, input logic [3:0] op, input logic [31:0] addr);
    int o;
    o = int'(addr - BASE);
    case (op[2:0])
      3'b000:  return {{24{mdl[d][o][7]}}, mdl[d][o]};
      3'b100:  return {24'h0, mdl[d][o]};
      3'b001:  return {{16{mdl[d][o+1][7]}}, mdl[d][o+1], mdl[d][o]};
      3'b101:  return {16'h0, mdl[d][o+1], mdl[d][o]};
      default: return {mdl[d][o+3], mdl[d][o+2], mdl[d][o+1], mdl[d][o]};
    endcase
  endfunction

  task automatic model_store(input int d, input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wd);
    int o;
    o = int'(addr - BASE);
    mdl[d][o] = wd[7:0];
    if (op[1:0] != 2'b00) mdl[d][o+1] = wd[15:8];
    if (op[1:0] == 2'b10) begin
      mdl[d][o+2] = wd[23:16];
      mdl[d][o+3] = wd[31:24];
    end
  endtask

  task automatic set_idle(input int d);
    exp_stall[d] = 1'b0;
    exp_valid[d] = 1'b0;
    exp_rdata[d] = 32'h0;
    exp_rd[d]    = 5'd0;
    exp_we[d]    = 1'b0;
    exp_fault[d] = 1'b0;
    exp_faddr[d] = model_faddr[d];
  endtask

  // One request on DUT d. flush_at = cycle index (0 = acceptance cycle) in
  // which flush_i is raised, or -1 for none. Response comes lat cycles after
  // acceptance: 1 for faults, else WAIT_CYCLES+1.
  task automatic do_req(input int d, input logic [3:0] op, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [4:0] rdn, input int flush_at);
    bit f;
    int lat;
    int k;
    bit done;
    f   = model_fault(op, addr);
    lat = f ? 1 : ((d == 0) ? 2 : 1);
    bus[d].addr     = addr;
    bus[d].w_data   = wd;
    bus[d].r_data   = $urandom;
    bus[d].write_en = 1'($urandom);
    bus[d].mem_op   = op;
    bus[d].mem_rd   = rdn;
    k    = 0;
    done = 1'b0;
    while (!done) begin
      flush[d] = (k == flush_at);
      set_idle(d);
      if (k == flush_at) begin
        exp_stall[d] = (k > 0) && (k < lat);
      end else if (k < lat) begin
        exp_stall[d] = 1'b1;
      end else if (f) begin
        model_faddr[d] = addr;
        exp_fault[d]   = 1'b1;
        exp_faddr[d]   = addr;
      end else begin
        exp_valid[d] = 1'b1;
        if (op[3]) begin
          model_store(d, op, addr, wd);
        end else begin
          exp_rdata[d] = model_load(d, op, addr);
          exp_rd[d]    = rdn;
          exp_we[d]    = (rdn != 5'd0);
        end
      end
      @(negedge clk);
      if (k == lat) begin
        last_valid = valid[d];
        last_we    = we[d];
        last_fault = flt[d];
        last_rdata = rdata[d];
        last_faddr = faddr[d];
        last_rd    = rd[d];
        last_t     = $time;
      end
      @(posedge clk);
      #1;
      if (k == flush_at || k == lat) done = 1'b1;
      k++;
    end
    flush[d]      = 1'b0;
    bus[d].mem_op = core::MEM_NOP;
    set_idle(d);
  endtask

  task automatic gap(input int d, input int n);
    for (int i = 0; i < n; i++) begin
      bus[d].mem_op = core::MEM_NOP;
      set_idle(d);
      @(negedge clk);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic fill(input int d);
    for (int i = 0; i < DEPTH; i++) do_req(d, OP_SW, BASE + 32'(4 * i), $urandom, 5'd0, -1);
  endtask

  task automatic rand_req(input int d);
    logic [3:0]  op;
    logic [31:0] addr;
    logic [31:0] mask;
    int          r;
    int          fa;
    case ($urandom_range(0, 7))
      0:       op = OP_LB;
      1:       op = OP_LH;
      2:       op = OP_LW;
      3:       op = OP_LBU;
      4:       op = OP_LHU;
      5:       op = OP_SB;
      6:       op = OP_SH;
      default: op = OP_SW;
    endcase
    r = int'($urandom_range(0, 9));
    if (r == 0) begin
      addr = BASE - 32'($urandom_range(1, 16));
    end else if (r == 1) begin
      addr = BASE + SPAN + 32'($urandom_range(0, 16));
    end else begin
      addr = BASE + 32'($urandom_range(0, DEPTH * 4 - 1));
      mask = (op[1:0] == 2'b00) ? 32'd0 : ((op[1:0] == 2'b01) ? 32'd1 : 32'd3);
      if (r > 3) addr = addr & ~mask;
    end
    fa = -1;
    if ($urandom_range(0, 7) == 0) fa = int'($urandom_range(0, 2));
    do_req(d, op, addr, $urandom, 5'($urandom), fa);
    gap(d, ($urandom_range(0, 2) == 0) ? 1 : 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    time t_first;
    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      bus[d]         = '0;
      bus[d].mem_op  = core::MEM_NOP;
      flush[d]       = 1'b0;
      model_faddr[d] = 32'h0;
      set_idle(d);
    end
    #1 chk_on = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    gap(0, 2);

    // --- DUT A (WAIT_CYCLES=1), directed ---
    do_req(0, OP_SW, 32'h2004, 32'hDEAD_BEEF, 5'd9, -1);
    chk("sw_valid", 32'(last_valid), 32'd1);
    chk("sw_we", 32'(last_we), 32'd0);
    chk("sw_rdata", last_rdata, 32'h0);
    gap(0, 1);
    do_req(0, OP_LW, 32'h2004, 32'h0, 5'd5, -1);
    chk("lw_rdata", last_rdata, 32'hDEAD_BEEF);
    chk("lw_rd", 32'(last_rd), 32'd5);
    chk("lw_we", 32'(last_we), 32'd1);
    do_req(0, OP_LB, 32'h2007, 32'h0, 5'd6, -1);
    chk("lb_rdata", last_rdata, 32'hFFFF_FFDE);
    do_req(0, OP_LBU, 32'h2007, 32'h0, 5'd6, -1);
    chk("lbu_rdata", last_rdata, 32'h0000_00DE);
    do_req(0, OP_LH, 32'h2006, 32'h0, 5'd6, -1);
    chk("lh_rdata", last_rdata, 32'hFFFF_DEAD);
    do_req(0, OP_LHU, 32'h2004, 32'h0, 5'd6, -1);
    chk("lhu_rdata", last_rdata, 32'h0000_BEEF);
    do_req(0, OP_SB, 32'h2005, 32'h0000_0012, 5'd0, -1);
    do_req(0, OP_LW, 32'h2004, 32'h0, 5'd1, -1);
    chk("sb_then_lw", last_rdata, 32'hDEAD_12EF);
    do_req(0, OP_SH, 32'h2006, 32'h0000_5678, 5'd0, -1);
    do_req(0, OP_LW, 32'h2004, 32'h0, 5'd1, -1);
    chk("sh_then_lw", last_rdata, 32'h5678_12EF);
    do_req(0, OP_LW, 32'h2006, 32'h0, 5'd4, -1);
    chk("mis_lw_fault", 32'(last_fault), 32'd1);
    chk("mis_lw_faddr", last_faddr, 32'h2006);
    chk("mis_lw_we", 32'(last_we), 32'd0);
    chk("mis_lw_valid", 32'(last_valid), 32'd0);
    do_req(0, OP_SW, 32'h2006, 32'hFFFF_FFFF, 5'd0, -1);
    do_req(0, OP_LW, 32'h2004, 32'h0, 5'd1, -1);
    chk("ram_unchanged", last_rdata, 32'h5678_12EF);
    do_req(0, OP_SW, 32'h1FFC, 32'h1111_1111, 5'd0, -1);
    chk("below_base_fault", 32'(last_fault), 32'd1);
    chk("below_base_faddr", last_faddr, 32'h1FFC);
    do_req(0, OP_LW, BASE + SPAN, 32'h0, 5'd2, -1);
    chk("above_top_fault", 32'(last_fault), 32'd1);
    chk("above_top_faddr", last_faddr, 32'h2100);
    gap(0, 2);
    do_req(0, OP_SW, 32'h2004, 32'h2222_2222, 5'd0, 1);
    do_req(0, OP_LW, 32'h2004, 32'h0, 5'd3, -1);
    chk("flushed_store", last_rdata, 32'h5678_12EF);

    // Reset in the WAIT cycle of a store
    bus[0].addr   = 32'h2004;
    bus[0].w_data = 32'hCAFE_F00D;
    bus[0].mem_op = OP_SW;
    bus[0].mem_rd = 5'd0;
    set_idle(0);
    exp_stall[0] = 1'b1;
    @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_async_stall", 32'(stall[0]), 32'd0);
    chk("rst_async_valid", 32'(valid[0]), 32'd0);
    chk("rst_async_faddr", faddr[0], 32'h0);
    model_faddr[0] = 32'h0;
    model_faddr[1] = 32'h0;
    bus[0].mem_op  = core::MEM_NOP;
    set_idle(0);
    set_idle(1);
    @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    gap(0, 1);
    do_req(0, OP_LW, 32'h2004, 32'h0, 5'd7, -1);
    chk("rst_no_write", last_rdata, 32'h5678_12EF);

    // --- DUT A random ---
    fill(0);
    for (int i = 0; i < 300; i++) rand_req(0);
    gap(0, 2);

    // --- DUT B (WAIT_CYCLES=0), directed ---
    do_req(1, OP_SW, 32'h2000, 32'hA5A5_0001, 5'd0, -1);
    do_req(1, OP_SW, 32'h2004, 32'h0000_C0DE, 5'd0, -1);
    gap(1, 1);
    do_req(1, OP_LW, 32'h2000, 32'h0, 5'd3, -1);
    t_first = last_t;
    chk("b_lw0_rdata", last_rdata, 32'hA5A5_0001);
    chk("b_lw0_we", 32'(last_we), 32'd1);
    do_req(1, OP_LW, 32'h2004, 32'h0, 5'd0, -1);
    chk("b_lw1_rdata", last_rdata, 32'h0000_C0DE);
    chk("b_rd0_we", 32'(last_we), 32'd0);
    chk("b_pulse_spacing", 32'(last_t - t_first), 32'd20);

    // --- DUT B random ---
    fill(1);
    for (int i = 0; i < 300; i++) rand_req(1);
    gap(1, 2);

    chk_on = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Responder end of the core's memory-control bus. Consumes the `core::mem_cntrl_bus_t` request driven by the execute-stage memory unit and performs the access against an internal byte-addressed data RAM.
- Executes loads and stores (byte, half, word), applies byte enables and load sign/zero extension, and inserts programmable wait states.
- Returns load data with the destination register to writeback, and holds the pipeline via a stall output while an access is in flight.

Parameters:
- DEPTH_WORDS, 1024, number of 32-bit words in the data RAM; must be a power of 2.
- WAIT_CYCLES, 1, extra cycles per access; range 0..15.
- BASE_ADDR, 32'h0000_2000, byte address that maps to word 0.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  reset, asynchronous, active-low.
- mem_bus_i  in  core::mem_cntrl_bus_t  request: addr, w_data, mem_op, mem_rd (write_en and r_data fields ignored).
- flush_i  in  1  kill the in-flight request; a store not yet committed is dropped.
- stall_o  out  1  pipeline must hold mem_bus_i stable.
- resp_valid_o  out  1  one-cycle pulse, access complete.
- rdata_o  out  32  extended load data; 0 for stores.
- rd_o  out  5  load destination register; 0 for stores and faults.
- we_o  out  1  register-file write enable; set only for a load with rd≠0 and no fault.
- fault_o  out  1  one-cycle pulse, misaligned or out-of-range access.
- fault_addr_o  out  32  faulting address, held until the next fault.

Behaviour:
- Encoding (core package):
  - mem_op[3]=STORE_PRFX(1) marks a store; mem_op[2:0]=RISC-V funct3 (000 B, 001 H, 010 W, 100 BU, 101 HU).
  - MEM_NOP=4'b0011.
  - A request is present when mem_op≠MEM_NOP.
- Reset (async): FSM→IDLE, counter 0, all outputs 0, fault_addr_o 0. RAM contents are not reset.
- FSM states IDLE, WAIT, RESP:
  - IDLE: if a request is present and flush_i=0, latch addr/w_data/mem_op/mem_rd and run the check (below).
    - Check fails: go to RESP with the fault flag set.
    - Check passes: go to WAIT if WAIT_CYCLES>0 (counter loads WAIT_CYCLES-1), else RESP.
  - WAIT: decrement the counter; at 0 go to RESP.
  - RESP: perform the access (RAM write or read), pulse resp_valid_o (or fault_o on fault), go to IDLE.
- Latency: request to resp_valid_o = WAIT_CYCLES+1 cycles.
- Back-to-back: a request held after RESP is re-accepted in the next IDLE cycle. The pipeline advances on resp_valid_o, so the same request is never issued twice.
- stall_o:
  - Combinational: 1 when (IDLE and request present and flush_i=0), or state≠IDLE and not RESP.
  - 0 in RESP, so the pipeline advances in the same cycle as the response.
- Check:
  - Word access needs addr[1:0]=0; half access needs addr[0]=0.
  - Address must satisfy addr-BASE_ADDR < DEPTH_WORDS*4, computed with 32-bit unsigned subtraction (wrap below BASE_ADDR is out of range).
  - A faulting store writes nothing; a faulting load asserts no we_o.
- Store:
  - Byte enables: SB → 1 lane at addr[1:0]; SH → lanes {addr[1],0} and {addr[1],1}; SW → all 4.
  - w_data is replicated: byte to all lanes, half to both halves.
  - Word index = (addr-BASE_ADDR)>>2.
- Load:
  - Select lane(s) by addr[1:0].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
- flush_i in WAIT or RESP (before the edge at which the RESP access occurs): abort to IDLE, no write, no pulse. flush_i has priority over completion.
- Reset mid-access: abort immediately, no write.

Test Plan:
- Reset with WAIT_CYCLES=1: stall_o, resp_valid_o and rdata_o all 0. SW addr 0x2004 data 0xDEADBEEF → stall_o high 2 cycles, resp_valid_o pulses in cycle 2, we_o=0.
- LW 0x2004, rd=5 → rdata_o=0xDEADBEEF, rd_o=5, we_o=1. Then LB 0x2007 → 0xFFFFFFDE; LBU 0x2007 → 0x000000DE; LH 0x2006 → 0xFFFFDEAD; LHU 0x2004 → 0x0000BEEF.
- SB 0x2005 data 0x12, then LW 0x2004 → 0xDEAD12EF. SH 0x2006 data 0x5678, then LW → 0x567812EF.
- LW 0x2006 → fault_o=1, fault_addr_o=0x2006, we_o=0, RAM unchanged. SW 0x1FFC → fault. LW 0x2000+DEPTH_WORDS*4 → fault.
- Flush during a pending SW (flush_i asserted in WAIT) → no resp_valid_o pulse, a later LW returns the old data. Reset asserted during WAIT → outputs 0 asynchronously.
- WAIT_CYCLES=0: LW completes in 1 cycle. Two back-to-back LWs to 0x2000/0x2004 → two resp_valid_o pulses 2 cycles apart. LW with rd=0 → we_o=0.
